regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a built-in busy scoreboard. It replaces the fixed 16×32, one-write/two-read register file in the processor datapath. Adds:
- configurable width, depth and read-port count;
- a second write port;
- write-to-read bypass;
- per-register reservation tracking, so issue logic can detect pending results.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1–4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset)
- WR  in  1  write enable, port 1
- Sel_i1  in  ADDR_W  write address, port 1
- Ip1  in  DATA_W  write data, port 1
- WR2  in  1  write enable, port 2
- Sel_i2  in  ADDR_W  write address, port 2
- Ip2  in  DATA_W  write data, port 2
- RD  in  1  read enable, common to all read ports
- Sel_o  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- Op  out  NUM_RD*DATA_W  packed registered read data
- Rdy  out  NUM_RD  per-port "register not busy" flag, registered with Op
- Rsv  in  1  reserve (mark busy) request
- Sel_r  in  ADDR_W  register to reserve

## Operation
- **Storage:** 2**ADDR_W words of DATA_W bits, plus one busy bit per word.
- **Writes:**
  - WR=1 writes Ip1 to reg[Sel_i1] at the edge.
  - WR2=1 writes Ip2 to reg[Sel_i2].
  - Both enabled to the same address: port 2 wins.
- **Reads:**
  - RD=1: each port k loads Op[k] at the edge.
  - RD=0: Op and Rdy hold their previous values.
- **Bypass priority for read data:**
  1. Ip2 if WR2 and Sel_i2 == Sel_o[k];
  2. else Ip1 if WR and Sel_i1 == Sel_o[k];
  3. else reg[Sel_o[k]].
- **Scoreboard:**
  - Rsv=1 sets busy[Sel_r].
  - Any enabled write clears busy of its address.
  - Rsv and a write to the same address in the same cycle: busy ends set (Rsv wins).
- **Rdy[k]** (sampled when RD=1):
  - 1 if busy[Sel_o[k]] is clear;
  - 1 if the register is being written this cycle and not simultaneously reserved;
  - otherwise 0.
- **Duplicate addresses:** multiple read ports addressing the same register all receive identical data.

## Timing
- Read latency is 1 cycle: address and RD at edge N give Op/Rdy valid after edge N.
- Write is visible:
  - to a same-cycle read through the bypass (Op updates at the same edge);
  - from the array for reads at edge N+1 onward.
- Reset (rst=0 at an edge):
  - all registers = 0, all busy = 0, Op = 0, Rdy = all ones;
  - WR, WR2, Rsv and RD are ignored in that cycle.
- Reset asserted mid-operation discards in-flight reads and reservations. The first post-reset read returns 0.
- No stall or backpressure: every enabled operation completes in its cycle.

## Configuration
- REGFILE_ZERO_REG_EN defined: register 0 is hard-wired zero.
  - Writes to address 0 on either port are dropped, and do not bypass.
  - Reads of address 0 return 0 with Rdy=1.
  - Rsv with Sel_r=0 is ignored.
- Undefined: register 0 behaves as an ordinary register.

## Structure
- **regfile_pkg:** default DATA_W/ADDR_W/NUM_RD constants, a MAX_RD=4 limit constant, and a zero-register address constant.
- **regfile_scoreboard** sub-module holds the busy vector. It takes Rsv/Sel_r and both write enables/addresses, and returns a per-read-port ready vector.
- The top level holds the data array, bypass muxes and output registers.

## Test plan
Defaults apply (DATA_W=32, ADDR_W=4, NUM_RD=2).
1. **Reset:** rst=0 for 2 cycles, then RD=1, Sel_o={5,2} -> Op={0,0}, Rdy=2'b11.
2. **Basic write/read:**
   - WR=1, Sel_i1=2, Ip1=AAAA_BBBB; next cycle WR2=1, Sel_i2=5, Ip2=1234_5678;
   - then RD=1, Sel_o={5,2} -> Op={1234_5678, AAAA_BBBB}.
3. **Conflict and bypass:**
   - WR/WR2 both to reg 7 with DEAD_0001/DEAD_0002, and RD=1, Sel_o={7,7} the same cycle -> both Op=DEAD_0002;
   - a later read of reg 7 -> DEAD_0002.
4. **Scoreboard:**
   - Rsv=1, Sel_r=3; next cycle read reg 3 -> Rdy[0]=0;
   - WR=1, Sel_i1=3, Ip1=0000_00FF with a same-cycle read -> Op=0000_00FF, Rdy=1;
   - Rsv and write to 3 in the same cycle -> subsequent Rdy=0.
5. **Hold and reset mid-operation:**
   - RD=0 while registers change -> Op unchanged;
   - rst=0 one cycle after writing reg 4 -> a read of 4 returns 0, Rdy=1.
6. **Zero register (REGFILE_ZERO_REG_EN defined):**
   - WR=1, Sel_i1=0, Ip1=FFFF_FFFF with a same-cycle read of 0 -> Op=0;
   - Rsv, Sel_r=0 -> Rdy stays 1;
   - without the macro, the same stimulus -> Op=FFFF_FFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the multi-port register file.
// Default geometry, the read-port limit and the address of the optional
// hard-wired zero register (enabled by REGFILE_ZERO_REG_EN in regfile_mp).
package regfile_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 4;
    localparam int NUM_RD_DEF    = 2;
    localparam int MAX_RD        = 4;
    localparam int ZERO_REG_ADDR = 0;

    // True when a read-port count lies in the supported range.
    function automatic bit rd_count_ok(input int n);
        return (n >= 1) && (n <= MAX_RD);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register.
// A reservation marks a register busy; any write to it clears the bit.
// When a reservation and a write hit the same register in one cycle,
// the reservation wins. The ready vector is combinational and is
// registered by the top level together with the read data.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsv_i,
    input  logic [ADDR_W-1:0]        sel_r_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic                     we2_i,
    input  logic [ADDR_W-1:0]        waddr2_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD-1:0]        rdy_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: writes clear first, then a reservation sets.
    always_comb begin
        busy_d = busy_q;
        if (we1_i) begin
            busy_d[waddr1_i] = 1'b0;
        end
        if (we2_i) begin
            busy_d[waddr2_i] = 1'b0;
        end
        if (rsv_i) begin
            busy_d[sel_r_i] = 1'b1;
        end
    end

    // Busy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Ready per read port: idle register, or one being written now and
    // not re-reserved in the same cycle.
    always_comb begin
        rdy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            logic              wr_hit;
            logic              rsv_hit;
            a       = raddr_i[k*ADDR_W +: ADDR_W];
            wr_hit  = (we1_i && (waddr1_i == a)) || (we2_i && (waddr2_i == a));
            rsv_hit = rsv_i && (sel_r_i == a);
            rdy_o[k] = !busy_q[a] || (wr_hit && !rsv_hit);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file, two write ports, NUM_RD read
// ports with write-to-read bypass and a busy scoreboard.
// Optional feature: define REGFILE_ZERO_REG_EN to hard-wire register 0
// to zero (writes and reservations of address 0 are dropped).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     WR,
    input  logic [ADDR_W-1:0]        Sel_i1,
    input  logic [DATA_W-1:0]        Ip1,
    input  logic                     WR2,
    input  logic [ADDR_W-1:0]        Sel_i2,
    input  logic [DATA_W-1:0]        Ip2,
    input  logic                     RD,
    input  logic [NUM_RD*ADDR_W-1:0] Sel_o,
    output logic [NUM_RD*DATA_W-1:0] Op,
    output logic [NUM_RD-1:0]        Rdy,
    input  logic                     Rsv,
    input  logic [ADDR_W-1:0]        Sel_r
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit RD_CFG_OK = rd_count_ok(NUM_RD);

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] op_q;
    logic [NUM_RD*DATA_W-1:0] op_d;
    logic [NUM_RD-1:0]        rdy_q;
    logic [NUM_RD-1:0]        sb_rdy;

    // Effective write/reserve enables after zero-register masking.
    logic we1;
    logic we2;
    logic rsv_eff;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_ADDR);
    assign we1     = WR  && (Sel_i1 != ZERO_ADDR);
    assign we2     = WR2 && (Sel_i2 != ZERO_ADDR);
    assign rsv_eff = Rsv && (Sel_r  != ZERO_ADDR);
`else
    assign we1     = WR;
    assign we2     = WR2;
    assign rsv_eff = Rsv;
`endif

    // Array next state: port 2 is applied last so it wins on a collision.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we1) begin
            mem_d[Sel_i1] = Ip1;
        end
        if (we2) begin
            mem_d[Sel_i2] = Ip2;
        end
    end

    // Storage array; reset clears every word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read data per port: port-2 bypass, then port-1 bypass, then array.
    always_comb begin
        op_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            a = Sel_o[k*ADDR_W +: ADDR_W];
            if (we2 && (Sel_i2 == a)) begin
                op_d[k*DATA_W +: DATA_W] = Ip2;
            end else if (we1 && (Sel_i1 == a)) begin
                op_d[k*DATA_W +: DATA_W] = Ip1;
            end else begin
                op_d[k*DATA_W +: DATA_W] = mem_q[a];
            end
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_i    (rsv_eff),
        .sel_r_i  (Sel_r),
        .we1_i    (we1),
        .waddr1_i (Sel_i1),
        .we2_i    (we2),
        .waddr2_i (Sel_i2),
        .raddr_i  (Sel_o),
        .rdy_o    (sb_rdy)
    );

    // Output registers: load on RD, hold otherwise; reset gives 0 / all ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q  <= '0;
            rdy_q <= '1;
        end else if (RD && RD_CFG_OK) begin
            op_q  <= op_d;
            rdy_q <= sb_rdy;
        end
    end

    assign Op  = op_q;
    assign Rdy = rdy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp at default geometry
// (32-bit data, 16 registers, 2 read ports). Expected values are
// hand-computed; the zero-register expectations follow REGFILE_ZERO_REG_EN.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              WR, WR2, RD, Rsv;
    logic [AW-1:0]     Sel_i1, Sel_i2, Sel_r;
    logic [DW-1:0]     Ip1, Ip2;
    logic [NR*AW-1:0]  Sel_o;
    logic [NR*DW-1:0]  Op;
    logic [NR-1:0]     Rdy;

    int n_checks = 0;
    int n_errors = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk    (clk),
        .rst    (rst),
        .WR     (WR),
        .Sel_i1 (Sel_i1),
        .Ip1    (Ip1),
        .WR2    (WR2),
        .Sel_i2 (Sel_i2),
        .Ip2    (Ip2),
        .RD     (RD),
        .Sel_o  (Sel_o),
        .Op     (Op),
        .Rdy    (Rdy),
        .Rsv    (Rsv),
        .Sel_r  (Sel_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WR = 0; WR2 = 0; RD = 0; Rsv = 0;
    endtask

    initial begin
        logic [NR*DW-1:0] held;
        logic [DW-1:0]    zexp;

        rst = 0; idle();
        Sel_i1 = '0; Sel_i2 = '0; Sel_r = '0; Ip1 = '0; Ip2 = '0; Sel_o = '0;

        // 1. reset
        tick(); tick();
        check("rst_op", 64'(Op), 64'h0);
        check("rst_rdy", 64'(Rdy), 64'h3);
        rst = 1;
        RD = 1; Sel_o = {4'd5, 4'd2};
        tick();
        check("post_rst_op", 64'(Op), 64'h0);
        check("post_rst_rdy", 64'(Rdy), 64'h3);
        idle();

        // 2. basic write/read
        WR = 1; Sel_i1 = 4'd2; Ip1 = 32'hAAAA_BBBB;
        tick(); idle();
        WR2 = 1; Sel_i2 = 4'd5; Ip2 = 32'h1234_5678;
        tick(); idle();
        RD = 1; Sel_o = {4'd5, 4'd2};
        tick(); idle();
        check("basic_rd", 64'(Op), {32'h1234_5678, 32'hAAAA_BBBB});

        // 3. dual-write conflict with same-cycle bypass
        WR = 1; Sel_i1 = 4'd7; Ip1 = 32'hDEAD_0001;
        WR2 = 1; Sel_i2 = 4'd7; Ip2 = 32'hDEAD_0002;
        RD = 1; Sel_o = {4'd7, 4'd7};
        tick(); idle();
        check("conflict_bypass", 64'(Op), {32'hDEAD_0002, 32'hDEAD_0002});
        RD = 1; Sel_o = {4'd2, 4'd7};
        tick(); idle();
        check("conflict_array", 64'(Op), {32'hAAAA_BBBB, 32'hDEAD_0002});
        check("conflict_rdy", 64'(Rdy), 64'h3);

        // 4. scoreboard
        Rsv = 1; Sel_r = 4'd3;
        tick(); idle();
        RD = 1; Sel_o = {4'd2, 4'd3};
        tick(); idle();
        check("rsv_busy_rdy", 64'(Rdy), 64'h2);
        WR = 1; Sel_i1 = 4'd3; Ip1 = 32'h0000_00FF;
        RD = 1; Sel_o = {4'd2, 4'd3};
        tick(); idle();
        check("wr_clear_op", 64'(Op[DW-1:0]), 64'h0000_00FF);
        check("wr_clear_rdy", 64'(Rdy), 64'h3);
        RD = 1;
        tick(); idle();
        check("after_clear_rdy", 64'(Rdy), 64'h3);
        check("after_clear_op", 64'(Op[DW-1:0]), 64'h0000_00FF);
        Rsv = 1; Sel_r = 4'd3;
        WR = 1; Sel_i1 = 4'd3; Ip1 = 32'h0000_0011;
        RD = 1;
        tick(); idle();
        check("rsv_wr_same_op", 64'(Op[DW-1:0]), 64'h0000_0011);
        check("rsv_wr_same_rdy", 64'(Rdy), 64'h3);
        RD = 1;
        tick(); idle();
        check("rsv_wins_rdy", 64'(Rdy), 64'h2);
        WR2 = 1; Sel_i2 = 4'd3; Ip2 = 32'h0000_0022;
        RD = 1;
        tick(); idle();
        check("wr2_clear_op", 64'(Op[DW-1:0]), 64'h0000_0022);
        check("wr2_clear_rdy", 64'(Rdy), 64'h3);
        RD = 1;
        tick(); idle();
        check("wr2_after_rdy", 64'(Rdy), 64'h3);

        // 5. hold with RD=0, then reset mid-operation
        RD = 1; Sel_o = {4'd5, 4'd2};
        tick(); idle();
        held = {32'h1234_5678, 32'hAAAA_BBBB};
        check("pre_hold", 64'(Op), 64'(held));
        WR = 1; Sel_i1 = 4'd2; Ip1 = 32'h0000_0099;
        WR2 = 1; Sel_i2 = 4'd5; Ip2 = 32'h0000_0077;
        Rsv = 1; Sel_r = 4'd2;
        tick(); idle();
        check("hold_op", 64'(Op), 64'(held));
        check("hold_rdy", 64'(Rdy), 64'h3);
        WR = 1; Sel_i1 = 4'd4; Ip1 = 32'h0000_4444;
        tick(); idle();
        rst = 0;
        RD = 1; Sel_o = {4'd4, 4'd4};
        WR2 = 1; Sel_i2 = 4'd4; Ip2 = 32'h0000_0005;
        Rsv = 1; Sel_r = 4'd4;
        tick(); idle();
        check("mid_rst_op", 64'(Op), 64'h0);
        check("mid_rst_rdy", 64'(Rdy), 64'h3);
        rst = 1;
        RD = 1; Sel_o = {4'd2, 4'd4};
        tick(); idle();
        check("post_mid_rst_op", 64'(Op), 64'h0);
        check("post_mid_rst_rdy", 64'(Rdy), 64'h3);

        // 6. register 0
`ifdef REGFILE_ZERO_REG_EN
        zexp = 32'h0;
`else
        zexp = 32'hFFFF_FFFF;
`endif
        WR = 1; Sel_i1 = 4'd0; Ip1 = 32'hFFFF_FFFF;
        RD = 1; Sel_o = {4'd0, 4'd0};
        tick(); idle();
        check("zero_bypass", 64'(Op), {zexp, zexp});
        RD = 1;
        tick(); idle();
        check("zero_array", 64'(Op), {zexp, zexp});
        Rsv = 1; Sel_r = 4'd0;
        tick(); idle();
        RD = 1; Sel_o = {4'd5, 4'd0};
        tick(); idle();
`ifdef REGFILE_ZERO_REG_EN
        check("zero_rsv_rdy", 64'(Rdy), 64'h3);
`else
        check("zero_rsv_rdy", 64'(Rdy), 64'h2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
